// File: rtl/cache_flag_pkg.sv
// cache_flag_pkg
// Shared types for the cache flag array: walker state and walk mode
// enums, plus the width helper used to size way-select fields.
package cache_flag_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    WB_WAIT = 2'd2,
    DONE    = 2'd3
  } walk_state_e;

  typedef enum logic {
    MODE_CLEAN = 1'b0,
    MODE_INVAL = 1'b1
  } walk_mode_e;

  // max(1, clog2(n)): a way field is never zero bits wide, even for a
  // direct-mapped configuration.
  function automatic int way_bits(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/cache_flag_array_if.sv
// cache_flag_array_if
// Bundles the lookup/update port, the walker start/status signals and the
// write-back handshake between the cache controller (master) and the flag
// array (slave).
//   index/way            lookup and update address
//   valid_upd/_control   valid-bit write strobe and value
//   dirty_upd/_control   dirty-bit write strobe and value
//   valid_vec/dirty_vec  all-way flags at index (combinational)
//   victim_way           replacement candidate at index
//   flush_req/inval_req  walker start pulses
//   busy/done            walker status
//   wb_req/wb_index/wb_way/wb_ack  write-back handshake
interface cache_flag_array_if #(
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2
);
  import cache_flag_pkg::*;

  localparam int WAY_W = way_bits(WAYS);

  logic [INDEX_W-1:0] index;
  logic [WAY_W-1:0]   way;
  logic               valid_upd;
  logic               valid_control;
  logic               dirty_upd;
  logic               dirty_control;
  logic [WAYS-1:0]    valid_vec;
  logic [WAYS-1:0]    dirty_vec;
  logic [WAY_W-1:0]   victim_way;
  logic               flush_req;
  logic               inval_req;
  logic               busy;
  logic               done;
  logic               wb_req;
  logic [INDEX_W-1:0] wb_index;
  logic [WAY_W-1:0]   wb_way;
  logic               wb_ack;

  modport master (
    output index, way, valid_upd, valid_control, dirty_upd, dirty_control,
    output flush_req, inval_req, wb_ack,
    input  valid_vec, dirty_vec, victim_way, busy, done,
    input  wb_req, wb_index, wb_way
  );

  modport slave (
    input  index, way, valid_upd, valid_control, dirty_upd, dirty_control,
    input  flush_req, inval_req, wb_ack,
    output valid_vec, dirty_vec, victim_way, busy, done,
    output wb_req, wb_index, wb_way
  );

endinterface

// File: rtl/cache_flag_walker.sv
// cache_flag_walker
// Flush/invalidate walker. Steps an entry cursor {index, way} over every
// line, requests a write-back for each valid+dirty line and emits clear
// strobes for the entry under the cursor.
//   clk, rstn             clock, async active-low reset
//   flush_req, inval_req  start pulses (honoured only in IDLE)
//   wb_ack                write-back accepted
//   ent_valid, ent_dirty  flags of the entry under the cursor
//   busy, done            SCAN/WB_WAIT active; one-cycle completion
//   wb_req, wb_index, wb_way  write-back request for the cursor entry
//   clr_valid, clr_dirty  clear strobes for the cursor entry
module cache_flag_walker
  import cache_flag_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2,
  parameter int WAY_W   = way_bits(WAYS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush_req,
  input  logic               inval_req,
  input  logic               wb_ack,
  input  logic               ent_valid,
  input  logic               ent_dirty,
  output logic               busy,
  output logic               done,
  output logic               wb_req,
  output logic [INDEX_W-1:0] wb_index,
  output logic [WAY_W-1:0]   wb_way,
  output logic               clr_valid,
  output logic               clr_dirty
);

  localparam int SETS = 1 << INDEX_W;

  walk_state_e        state_q, state_d;
  walk_mode_e         mode_q, mode_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic               advance;
  logic               last_way;
  logic               last_ent;

  assign last_way = (way_q == WAY_W'(WAYS - 1));
  assign last_ent = last_way && (idx_q == INDEX_W'(SETS - 1));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    way_d     = way_q;
    advance   = 1'b0;
    clr_valid = 1'b0;
    clr_dirty = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_req || inval_req) begin
          mode_d  = inval_req ? MODE_INVAL : MODE_CLEAN;
          idx_d   = '0;
          way_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (ent_valid && ent_dirty) begin
          state_d = WB_WAIT;
        end else begin
          clr_valid = (mode_q == MODE_INVAL);
          advance   = 1'b1;
        end
      end
      WB_WAIT: begin
        if (wb_ack) begin
          clr_dirty = 1'b1;
          clr_valid = (mode_q == MODE_INVAL);
          advance   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Way is the fast-moving field of the cursor.
    if (advance) begin
      if (last_ent) begin
        state_d = DONE;
      end else begin
        state_d = SCAN;
        if (last_way) begin
          way_d = '0;
          idx_d = idx_q + 1'b1;
        end else begin
          way_d = way_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      mode_q  <= MODE_CLEAN;
      idx_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
    end
  end

  assign busy     = (state_q == SCAN) || (state_q == WB_WAIT);
  assign done     = (state_q == DONE);
  assign wb_req   = (state_q == WB_WAIT);
  assign wb_index = idx_q;
  assign wb_way   = way_q;

endmodule

// File: rtl/cache_flag_array.sv
// cache_flag_array
// Per-line valid/dirty flag store for a set-associative cache with a
// per-set round-robin victim pointer and a flush/invalidate walker.
//   clk   clock; all state changes on the rising edge
//   rstn  async active-low reset; clears all flags, pointers and walker
//   bus   cache_flag_array_if slave: lookup/update, victim, walker
//         start/status and write-back handshake
module cache_flag_array
  import cache_flag_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  cache_flag_array_if.slave     bus
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = way_bits(WAYS);

  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];
  logic [WAY_W-1:0]   rr_q    [SETS];

  logic               walk_busy;
  logic               walk_done;
  logic               walk_active;
  logic [INDEX_W-1:0] walk_index;
  logic [WAY_W-1:0]   walk_way;
  logic               ent_valid;
  logic               ent_dirty;
  logic               clr_valid;
  logic               clr_dirty;

  logic [WAYS-1:0]    set_valid;
  logic [WAY_W-1:0]   rr_cur;
  logic [WAY_W-1:0]   rr_next;
  logic               rr_advance;
  logic               way_ok;
  logic [WAY_W-1:0]   victim;

  // The walker reads the entry under its own cursor, independent of the
  // controller's lookup index.
  assign ent_valid = valid_q[walk_index][walk_way];
  assign ent_dirty = dirty_q[walk_index][walk_way];

  cache_flag_walker #(
    .INDEX_W (INDEX_W),
    .WAYS    (WAYS),
    .WAY_W   (WAY_W)
  ) u_walker (
    .clk       (clk),
    .rstn      (rstn),
    .flush_req (bus.flush_req),
    .inval_req (bus.inval_req),
    .wb_ack    (bus.wb_ack),
    .ent_valid (ent_valid),
    .ent_dirty (ent_dirty),
    .busy      (walk_busy),
    .done      (walk_done),
    .wb_req    (bus.wb_req),
    .wb_index  (walk_index),
    .wb_way    (walk_way),
    .clr_valid (clr_valid),
    .clr_dirty (clr_dirty)
  );

  // The DONE cycle still locks out external writes.
  assign walk_active = walk_busy || walk_done;

  assign set_valid = valid_q[bus.index];
  assign rr_cur    = rr_q[bus.index];
  assign way_ok    = (bus.way <= WAY_W'(WAYS - 1));

  // Pointer moves past a way only when that way is the one being filled.
  assign rr_advance = bus.valid_upd && bus.valid_control && (bus.way == rr_cur);
  assign rr_next    = (rr_cur == WAY_W'(WAYS - 1)) ? '0 : rr_cur + 1'b1;

  // Lowest-numbered invalid way wins; otherwise fall back to the pointer.
  always_comb begin
    victim = rr_cur;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) victim = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (walk_active) begin
      if (clr_valid) valid_q[walk_index][walk_way] <= 1'b0;
      if (clr_dirty) dirty_q[walk_index][walk_way] <= 1'b0;
    end else if (way_ok) begin
      if (bus.valid_upd) valid_q[bus.index][bus.way] <= bus.valid_control;
      if (bus.dirty_upd) dirty_q[bus.index][bus.way] <= bus.dirty_control;
      if (rr_advance)    rr_q[bus.index]             <= rr_next;
    end
  end

  assign bus.valid_vec  = set_valid;
  assign bus.dirty_vec  = dirty_q[bus.index];
  assign bus.victim_way = victim;
  assign bus.busy       = walk_busy;
  assign bus.done       = walk_done;
  assign bus.wb_index   = walk_index;
  assign bus.wb_way     = walk_way;

endmodule

// File: tb/tb_cache_flag_array.sv
// tb_cache_flag_array
// Directed bench for cache_flag_array (INDEX_W=6, WAYS=2). Expected
// write-back entries are queued when the dirty lines are planted and
// popped as the walker requests them.
module tb_cache_flag_array;
  import cache_flag_pkg::*;

  localparam int INDEX_W = 6;
  localparam int WAYS    = 2;
  localparam int WAY_W   = way_bits(WAYS);
  localparam int SETS    = 1 << INDEX_W;

  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic [WAY_W-1:0]   w;
  } ent_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cache_flag_array_if #(.INDEX_W(INDEX_W), .WAYS(WAYS)) bus ();

  cache_flag_array #(.INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_mis = 0;
  ent_t wb_exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.index = '0; bus.way = '0;
    bus.valid_upd = 1'b0; bus.valid_control = 1'b0;
    bus.dirty_upd = 1'b0; bus.dirty_control = 1'b0;
    bus.flush_req = 1'b0; bus.inval_req = 1'b0; bus.wb_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wr(input int idx, input int w, input logic vu, input logic v,
                    input logic du, input logic d);
    @(negedge clk);
    bus.index = idx[INDEX_W-1:0]; bus.way = w[WAY_W-1:0];
    bus.valid_upd = vu; bus.valid_control = v;
    bus.dirty_upd = du; bus.dirty_control = d;
    @(posedge clk);
    #1;
    bus.valid_upd = 1'b0; bus.dirty_upd = 1'b0;
  endtask

  task automatic look(input string tag, input int idx, input logic [1:0] ev,
                      input logic [1:0] ed, input int evict);
    @(negedge clk);
    bus.index = idx[INDEX_W-1:0];
    #1;
    chk({tag, ".valid_vec"}, bus.valid_vec, ev);
    chk({tag, ".dirty_vec"}, bus.dirty_vec, ed);
    if (evict >= 0) chk({tag, ".victim_way"}, bus.victim_way, evict);
  endtask

  task automatic start_walk(input logic fl, input logic inv);
    @(negedge clk);
    bus.flush_req = fl; bus.inval_req = inv;
    @(posedge clk);
    #1;
    bus.flush_req = 1'b0; bus.inval_req = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the request edge. wb_ack rises on
  // the ack_delay-th WB_WAIT cycle. With inject set, a stray request and
  // a flag write to set 20 are presented during the walk.
  task automatic run_walk(input int ack_delay, input bit inject,
                          output int busy_cnt, output int done_cyc, output int wb_eps);
    int   wait_n;
    bit   ack_prev;
    ent_t cur;
    wait_n = 0; ack_prev = 1'b0; cur = '0;
    busy_cnt = 0; done_cyc = -1; wb_eps = 0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      bus.wb_ack = 1'b0;
      if (inject && cyc == 10) begin
        bus.flush_req = 1'b1; bus.inval_req = 1'b1;
        bus.index = 6'd20; bus.way = '0;
        bus.valid_upd = 1'b1; bus.valid_control = 1'b1;
        bus.dirty_upd = 1'b1; bus.dirty_control = 1'b1;
      end else if (inject && cyc == 11) begin
        clear_inputs();
      end
      if (bus.busy) busy_cnt++;
      if (ack_prev) begin
        chk("wb_req_drop", bus.wb_req, 0);
        ack_prev = 1'b0;
        wait_n   = 0;
      end else if (bus.wb_req) begin
        if (wait_n == 0) begin
          wb_eps++;
          if (wb_exp_q.size() == 0) begin
            chk("wb_unexpected", bus.wb_req, 0);
          end else begin
            cur = wb_exp_q.pop_front();
            chk("wb_index", bus.wb_index, cur.idx);
            chk("wb_way", bus.wb_way, cur.w);
          end
        end else begin
          chk("wb_index_stable", bus.wb_index, cur.idx);
          chk("wb_way_stable", bus.wb_way, cur.w);
        end
        wait_n++;
        if (wait_n >= ack_delay) begin
          bus.wb_ack = 1'b1;
          ack_prev   = 1'b1;
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
    end
    bus.wb_ack = 1'b0;
    if (done_cyc < 0) chk("walk_timeout", bus.done, 1);
  endtask

  initial begin
    int busy_cnt, done_cyc, wb_eps, dn, seen;
    clear_inputs();

    // Reset state
    #12;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.wb_req", bus.wb_req, 0);
    chk("rst.wb_index", bus.wb_index, 0);
    chk("rst.wb_way", bus.wb_way, 0);
    chk("rst.valid_vec", bus.valid_vec, 0);
    chk("rst.victim", bus.victim_way, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Coinciding valid/dirty write; same-cycle read returns old value
    @(negedge clk);
    bus.index = 6'd5; bus.way = 1'b1;
    bus.valid_upd = 1'b1; bus.valid_control = 1'b1;
    bus.dirty_upd = 1'b1; bus.dirty_control = 1'b1;
    #1;
    chk("nobypass.valid_vec", bus.valid_vec, 0);
    @(posedge clk);
    #1;
    bus.valid_upd = 1'b0; bus.dirty_upd = 1'b0;
    look("set5", 5, 2'b10, 2'b10, 0);

    // Round-robin fills on set 3
    wr(3, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    look("fill0", 3, 2'b01, 2'b00, 1);
    wr(3, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    look("fill1", 3, 2'b11, 2'b00, 0);
    wr(3, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    look("fill2", 3, 2'b11, 2'b00, 1);

    // Flush of an all-clean cache with stray requests/writes mid-walk
    do_reset();
    wr(3, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    wr(3, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    wr(10, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    start_walk(1'b1, 1'b0);
    run_walk(1, 1'b1, busy_cnt, done_cyc, wb_eps);
    chk("clean.busy_cycles", busy_cnt, 128);
    chk("clean.done_cycle", done_cyc, 129);
    chk("clean.wb_episodes", wb_eps, 0);
    @(negedge clk);
    chk("clean.done_one_cycle", bus.done, 0);
    chk("clean.idle_after", bus.busy, 0);
    look("clean.set3", 3, 2'b11, 2'b00, -1);
    look("clean.set10", 10, 2'b01, 2'b00, -1);
    look("clean.set20_ignored", 20, 2'b00, 2'b00, 0);

    // Flush with two dirty lines, ack on the 3rd WB_WAIT cycle
    wr(0, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    wr(63, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    wb_exp_q.push_back('{idx: 6'd0,  w: 1'b1});
    wb_exp_q.push_back('{idx: 6'd63, w: 1'b0});
    start_walk(1'b1, 1'b0);
    run_walk(3, 1'b0, busy_cnt, done_cyc, wb_eps);
    chk("flush.wb_episodes", wb_eps, 2);
    chk("flush.done_cycle", done_cyc, 135);
    chk("flush.queue_empty", wb_exp_q.size(), 0);
    look("flush.set0", 0, 2'b10, 2'b00, -1);
    look("flush.set63", 63, 2'b01, 2'b00, -1);
    look("flush.set3", 3, 2'b11, 2'b00, -1);

    // Simultaneous inval+flush selects invalidate
    wr(2, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    wr(7, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    wr(40, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    wr(40, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    wb_exp_q.push_back('{idx: 6'd7,  w: 1'b1});
    wb_exp_q.push_back('{idx: 6'd40, w: 1'b0});
    start_walk(1'b1, 1'b1);
    run_walk(1, 1'b0, busy_cnt, done_cyc, wb_eps);
    chk("inval.wb_episodes", wb_eps, 2);
    chk("inval.done_cycle", done_cyc, 131);
    chk("inval.queue_empty", wb_exp_q.size(), 0);
    for (int s = 0; s < SETS; s++) look("inval.all_clear", s, 2'b00, 2'b00, -1);

    // Reset while in WB_WAIT aborts the walk
    wr(10, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    bus.index = 6'd10;
    start_walk(1'b1, 1'b0);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.wb_req) begin
        seen = 1;
        break;
      end
    end
    chk("abort.reached_wb_wait", seen, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort.wb_req", bus.wb_req, 0);
    chk("abort.busy", bus.busy, 0);
    chk("abort.valid_vec", bus.valid_vec, 0);
    chk("abort.dirty_vec", bus.dirty_vec, 0);
    @(negedge clk);
    rstn = 1'b1;
    dn = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    chk("abort.no_done", dn, 0);

    // Fresh flush after the aborted one completes normally
    wr(1, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    wb_exp_q.push_back('{idx: 6'd1, w: 1'b0});
    start_walk(1'b1, 1'b0);
    run_walk(2, 1'b0, busy_cnt, done_cyc, wb_eps);
    chk("restart.wb_episodes", wb_eps, 1);
    chk("restart.done_cycle", done_cyc, 131);
    chk("restart.queue_empty", wb_exp_q.size(), 0);
    look("restart.set1", 1, 2'b01, 2'b00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cache_flag_array.md
# cache_flag_array

Per-line valid/dirty flag store for the set-associative data cache, with a per-set round-robin victim pointer and a built-in flush/invalidate walker. It replaces the single-way 64-line flag register. It sits beside the tag and data arrays: the cache controller reads flags combinationally at the lookup index and writes them on fills and stores. The walker drives the write-back path during a full-cache clean or invalidate.

## Interface
- INDEX_W, 6, set index width; SETS = 2**INDEX_W
- WAYS, 2, associativity; power of two, 1..8
- WAY_W, derived, max(1, clog2(WAYS))
- clk  in  1  clock; all state changes on the rising edge
- rstn  in  1  asynchronous active-low reset
- index  in  INDEX_W  lookup/update set
- way  in  WAY_W  update way
- valid_upd, valid_control  in  1,1  write valid[index][way] <= valid_control
- dirty_upd, dirty_control  in  1,1  write dirty[index][way] <= dirty_control
- valid_vec, dirty_vec  out  WAYS  flags of all ways at index (combinational)
- victim_way  out  WAY_W  lowest-numbered invalid way at index, else rr_ptr[index]
- flush_req, inval_req  in  1  one-cycle start pulses
- busy  out  1  walker active
- done  out  1  one-cycle completion pulse
- wb_req  out  1  write-back request for the entry on wb_index/wb_way
- wb_index, wb_way  out  INDEX_W, WAY_W  entry to write back
- wb_ack  in  1  write-back accepted

## Operation
- Storage: valid[SETS][WAYS], dirty[SETS][WAYS], rr_ptr[SETS] (WAY_W bits).
- Updates: valid_upd and dirty_upd may coincide on the same entry; both apply. A read in the same cycle returns the old value; there is no bypass.
- rr_ptr[index] increments modulo WAYS when valid_upd=1, valid_control=1 and way==rr_ptr[index].
- Walker states: IDLE, SCAN, WB_WAIT, DONE. A 32-bit-capable entry counter ent = {index,way} spans 0..SETS*WAYS-1, way in the LSBs.
- IDLE: on flush_req or inval_req, capture mode (inval_req wins if both are set), clear ent, go to SCAN. Requests outside IDLE are ignored.
- SCAN: examine entry ent.
  - If valid&dirty, go to WB_WAIT.
  - Otherwise, in inval mode clear valid, then advance.
  - Advance means ent+1, or DONE if ent is last.
- WB_WAIT: wb_req=1 with wb_index/wb_way = ent, held stable until wb_ack is sampled high. On wb_ack, clear dirty; in inval mode also clear valid. Then advance as in SCAN.
- DONE: done=1 for one cycle, then IDLE.
- While busy or in DONE, external valid_upd/dirty_upd are ignored. Lookup outputs remain live. rr_ptr is not modified by the walker.
- Flush mode leaves valid bits untouched. Inval mode also resets nothing except valid/dirty.

## Timing
- Reset (asynchronous, any state): all valid, dirty and rr_ptr become 0; state becomes IDLE; busy, done and wb_req become 0; wb_index and wb_way become 0. A reset during a walk aborts it with no done pulse.
- Request sampled at edge N: busy=1 from cycle N+1.
- Each clean entry costs 1 cycle. Each dirty entry costs 1 SCAN cycle plus a WB_WAIT of at least 1 cycle (wb_ack may be high on the first WB_WAIT cycle).
- All-clean cache: busy for N+1..N+SETS*WAYS, done at cycle N+SETS*WAYS+1, busy=0 in DONE.
- wb_req deasserts in the cycle after the acknowledged edge.
- wb_ack outside WB_WAIT is ignored.
- Flag writes are visible on valid_vec/dirty_vec in the cycle after the write edge.

## Structure
- Package cache_flag_pkg: walker state enum (IDLE/SCAN/WB_WAIT/DONE), mode enum (MODE_CLEAN/MODE_INVAL), and the clog2 helper for WAY_W.
- Sub-module cache_flag_walker: FSM, entry counter, mode register and wb handshake. It emits per-entry clear strobes to the storage in the top level.
- Storage, rr_ptr and victim selection stay in cache_flag_array.

## Test plan
- Reset, then write valid[5][1]=1 and dirty[5][1]=1. Next cycle index=5 gives valid_vec=2'b10, dirty_vec=2'b10 and victim_way=0.
- Fill way 0 then way 1 of set 3 with valid_control=1. rr_ptr advances 0→1→0, and with both ways valid victim_way=0. A third fill on way 0 makes victim_way=1.
- flush_req on an all-clean cache (INDEX_W=6, WAYS=2): busy for 128 cycles, done at cycle 129, wb_req never asserted, valid bits unchanged.
- Dirty entries at (0,1) and (63,0), wb_ack delayed 3 cycles. Exactly two wb_req episodes occur, with wb_index/wb_way = 0/1 then 63/0, stable until ack. Afterwards all dirty=0 and valid is retained in flush mode.
- inval_req and flush_req asserted together: inval mode is selected. At done, all valid=0 and all dirty=0, and one write-back is issued per dirty line.
- rstn asserted low while in WB_WAIT: wb_req, busy and all flags drop to 0 immediately, and no done pulse appears. A new flush_req after release completes normally.
